alu_share_arbiter: RTL and testbench

- Shares one instance of the team's 8-bit combinational `alu` between N requesters, using round-robin arbitration.
- Each requester uses a valid/ready handshake. Results return through a single registered response channel, tagged with the requester id.
- An optional lock lets one requester issue back-to-back operation sequences, bounded by a starvation limit.
- Sits between the instruction-issue logic (or other clients) and the ALU.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 36 +++
 rtl/rr_arbiter.sv | 17 +
 rtl/alu_share_arbiter.sv | 113 +++++++++++
 tb/tb_alu_share_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op-codes, data widths and arbiter state encoding
package alu_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_DIV  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SHL  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SHR  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_ROL  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_ROR  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b1001;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b1010;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'b1011;
  localparam logic [OP_W-1:0] ALU_NAND = 4'b1100;
  localparam logic [OP_W-1:0] ALU_XNOR = 4'b1101;
  localparam logic [OP_W-1:0] ALU_GT   = 4'b1110;
  localparam logic [OP_W-1:0] ALU_EQ   = 4'b1111;
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  function automatic logic is_div_zero(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] b);
    return op == ALU_DIV && b == '0;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: 8-bit combinational ALU; CarryOut is always the carry of A+B
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   ALU_Sel,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              CarryOut
);
  logic [DATA_W:0] w_sum;
  assign w_sum = {1'b0, A} + {1'b0, B};
  assign CarryOut = w_sum[DATA_W];
  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      ALU_ADD:  ALU_Out = A + B;
      ALU_SUB:  ALU_Out = A - B;
      ALU_MUL:  ALU_Out = A * B;
      ALU_DIV:  ALU_Out = A / B;
      ALU_SHL:  ALU_Out = A << 1;
      ALU_SHR:  ALU_Out = A >> 1;
      ALU_ROL:  ALU_Out = {A[DATA_W-2:0], A[DATA_W-1]};
      ALU_ROR:  ALU_Out = {A[0], A[DATA_W-1:1]};
      ALU_AND:  ALU_Out = A & B;
      ALU_OR:   ALU_Out = A | B;
      ALU_XOR:  ALU_Out = A ^ B;
      ALU_NOR:  ALU_Out = ~(A | B);
      ALU_NAND: ALU_Out = ~(A & B);
      ALU_XNOR: ALU_Out = ~(A ^ B);
      ALU_GT:   ALU_Out = {{(DATA_W-1){1'b0}}, A > B};
      ALU_EQ:   ALU_Out = {{(DATA_W-1){1'b0}}, A == B};
      default:  ALU_Out = '0;
    endcase
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after the pointer, searching cyclically
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant
);
  // Walk offsets from farthest to nearest so the nearest valid requester wins
  always_comb begin
    o_grant = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_en && i_req[(int'(i_ptr) + k) % N]) o_grant = N'(1) << ((int'(i_ptr) + k) % N);
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one alu between N requesters with
// an optional bounded lock and a single registered, id-tagged response channel
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N = 4,
  parameter int IDW = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N-1:0]      req_lock,
  input  logic [N*8-1:0]    req_a,
  input  logic [N*8-1:0]    req_b,
  input  logic [N*4-1:0]    req_op,
  output logic [N-1:0]      req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_result,
  output logic              resp_carry,
  output logic              resp_err,
  output logic [IDW-1:0]    resp_id
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic              r_resp_valid, r_resp_carry, r_resp_err;
  logic [DATA_W-1:0] r_resp_result;
  logic [IDW-1:0]    r_resp_id, r_owner;
  logic [PW-1:0]     r_ptr;
  logic [0:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic              w_can, w_acc, w_lock, w_dz, w_alu_co;
  logic [N-1:0]      w_arb_grant, w_grant;
  logic [IDW-1:0]    w_idx;
  logic [PW-1:0]     w_nxt;
  logic [DATA_W-1:0] w_a, w_b, w_alu_out;
  logic [OP_W-1:0]   w_op;
  rr_arbiter #(.N(N)) u_rr (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .i_en   (r_state == ST_ARB),
    .o_grant(w_arb_grant)
  );
  // While locked the owner holds the grant even with its valid low
  assign w_grant = (r_state == ST_LOCKED) ? N'(1) << r_owner : w_arb_grant;
  assign w_can = !r_resp_valid || resp_ready;
  assign req_ready = {N{rst_n && w_can}} & w_grant;
  assign w_acc = |(req_valid & req_ready);
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < N; k++)
      if (w_grant[k]) w_idx = IDW'(k);
  end
  assign w_nxt = (w_idx == IDW'(N - 1)) ? '0 : PW'(w_idx + IDW'(1));
  assign w_lock = req_lock[w_idx];
  assign w_a = req_a[w_idx*DATA_W +: DATA_W];
  assign w_b = req_b[w_idx*DATA_W +: DATA_W];
  assign w_op = req_op[w_idx*OP_W +: OP_W];
  assign w_dz = is_div_zero(w_op, w_b);
  alu u_alu (
    .A       (w_a),
    .B       (w_b),
    .ALU_Sel (w_op),
    .ALU_Out (w_alu_out),
    .CarryOut(w_alu_co)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
      r_resp_carry  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_id     <= '0;
    end else if (w_acc) begin
      r_resp_valid  <= 1'b1;
      r_resp_result <= w_dz ? '1 : w_alu_out;
      r_resp_carry  <= w_op == ALU_ADD && w_alu_co;
      r_resp_err    <= w_dz;
      r_resp_id     <= w_idx;
    end else if (resp_ready) begin
      r_resp_valid  <= 1'b0;
    end
  end
  // In LOCKED, w_idx is the owner, so w_nxt is owner+1 on every exit path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_state <= ST_ARB;
      r_owner <= '0;
      r_cnt   <= '0;
    end else if (r_state == ST_ARB) begin
      if (w_acc) begin
        r_ptr <= w_nxt;
        if (w_lock && LOCK_MAX > 1) begin
          r_state <= ST_LOCKED;
          r_owner <= w_idx;
          r_cnt   <= CW'(1);
        end
      end
    end else if (w_acc && w_lock && int'(r_cnt) + 1 < LOCK_MAX) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (w_acc || !(w_lock || req_valid[r_owner])) begin
      r_state <= ST_ARB;
      r_ptr   <= w_nxt;
    end
  end
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign resp_carry  = r_resp_carry;
  assign resp_err    = r_resp_err;
  assign resp_id     = r_resp_id;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table vectors plus handshake sequences, checked through an expected-response queue
module tb_alu_share_arbiter;
  import alu_pkg::*;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int LOCK_MAX = 2;
  typedef struct packed {logic [7:0] res; logic c; logic e;} exp_t;
  typedef struct packed {exp_t x; logic [1:0] id;} sb_t;
  typedef struct {logic [7:0] a; logic [7:0] b; logic [3:0] op; logic [7:0] res; logic c; logic e;} vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_lock, req_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [N*4-1:0] req_op;
  logic resp_valid, resp_ready, resp_carry, resp_err;
  logic [7:0] resp_result;
  logic [IDW-1:0] resp_id;
  int checks = 0;
  int errors = 0;
  sb_t expq[$];
  exp_t exp_of[N];
  logic [19:0] prev_pl[N];
  logic [N-1:0] pend = '0;
  int rem[N];
  int acc_q[$];
  vec_t tbl[20];
  alu_share_arbiter #(.N(N), .IDW(IDW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_carry(resp_carry), .resp_err(resp_err), .resp_id(resp_id)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] r, input logic c, input logic e);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_op[4*id +: 4] = op;
    exp_of[id].res = r;
    exp_of[id].c = c;
    exp_of[id].e = e;
  endtask
  // One negedge sample: pop/compare responses, enforce the requester protocol, push accepted ops
  task automatic tick();
    sb_t s;
    @(negedge clk);
    if (!rst_n) begin
      expq.delete();
      pend = '0;
    end else begin
      if (resp_valid && resp_ready) begin
        chk("sb_nonempty", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          s = expq.pop_front();
          chk("resp", {resp_result, resp_carry, resp_err, resp_id}, s);
        end
      end
      chk("ready_onehot", $countones(req_ready) <= 1, 1);
      for (int i = 0; i < N; i++) begin
        if (pend[i])
          chk("protocol", {req_valid[i], req_a[8*i +: 8], req_b[8*i +: 8], req_op[4*i +: 4]}, {1'b1, prev_pl[i]});
        if (req_valid[i] && req_ready[i]) begin
          s.x = exp_of[i];
          s.id = 2'(i);
          expq.push_back(s);
        end
        prev_pl[i] = {req_a[8*i +: 8], req_b[8*i +: 8], req_op[4*i +: 4]};
      end
      pend = req_valid & ~req_ready;
    end
  endtask
  task automatic step();
    tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [7:0] r, input logic c, input logic e);
    int n = 0;
    set_req(id, a, b, op, r, c, e);
    req_valid[id] = 1'b1;
    do begin
      tick();
      n++;
    end while (!req_ready[id] && n < 50);
    chk("issue_ready", req_ready[id], 1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask
  // Each requester keeps valid until it has been accepted rem[i] times
  task automatic run_accepts(input int n, output int cyc);
    logic [N-1:0] w;
    acc_q.delete();
    cyc = 0;
    while (acc_q.size() < n && cyc < 40) begin
      tick();
      cyc++;
      w = req_valid & req_ready;
      for (int i = 0; i < N; i++)
        if (w[i]) acc_q.push_back(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (w[i]) begin
          rem[i]--;
          if (rem[i] == 0) req_valid[i] = 1'b0;
        end
    end
    chk("accept_count", acc_q.size(), n);
  endtask
  initial begin
    int cyc;
    tbl[0]  = '{8'd200, 8'd100, ALU_ADD,  8'd44,  1'b1, 1'b0};
    tbl[1]  = '{8'd7,   8'd3,   ALU_SUB,  8'd4,   1'b0, 1'b0};
    tbl[2]  = '{8'd20,  8'd13,  ALU_MUL,  8'd4,   1'b0, 1'b0};
    tbl[3]  = '{8'd9,   8'd0,   ALU_DIV,  8'hFF,  1'b0, 1'b1};
    tbl[4]  = '{8'd9,   8'd2,   ALU_DIV,  8'd4,   1'b0, 1'b0};
    tbl[5]  = '{8'h81,  8'h00,  ALU_SHL,  8'h02,  1'b0, 1'b0};
    tbl[6]  = '{8'h81,  8'h00,  ALU_SHR,  8'h40,  1'b0, 1'b0};
    tbl[7]  = '{8'h81,  8'h00,  ALU_ROL,  8'h03,  1'b0, 1'b0};
    tbl[8]  = '{8'h81,  8'h00,  ALU_ROR,  8'hC0,  1'b0, 1'b0};
    tbl[9]  = '{8'hF0,  8'h3C,  ALU_AND,  8'h30,  1'b0, 1'b0};
    tbl[10] = '{8'hF0,  8'h3C,  ALU_OR,   8'hFC,  1'b0, 1'b0};
    tbl[11] = '{8'hF0,  8'h3C,  ALU_XOR,  8'hCC,  1'b0, 1'b0};
    tbl[12] = '{8'hF0,  8'h3C,  ALU_NOR,  8'h03,  1'b0, 1'b0};
    tbl[13] = '{8'hF0,  8'h3C,  ALU_NAND, 8'hCF,  1'b0, 1'b0};
    tbl[14] = '{8'hF0,  8'h3C,  ALU_XNOR, 8'h33,  1'b0, 1'b0};
    tbl[15] = '{8'd5,   8'd3,   ALU_GT,   8'd1,   1'b0, 1'b0};
    tbl[16] = '{8'd3,   8'd5,   ALU_GT,   8'd0,   1'b0, 1'b0};
    tbl[17] = '{8'd7,   8'd7,   ALU_EQ,   8'd1,   1'b0, 1'b0};
    tbl[18] = '{8'd7,   8'd8,   ALU_EQ,   8'd0,   1'b0, 1'b0};
    tbl[19] = '{8'd200, 8'd100, ALU_SUB,  8'd100, 1'b0, 1'b0};
    rst_n = 1'b0;
    resp_ready = 1'b1;
    req_lock = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) set_req(i, 8'(10 * i + 1), 8'(i), ALU_ADD, 8'(11 * i + 1), 1'b0, 1'b0);
    req_valid = '1;
    #3;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_carry", resp_carry, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (2) begin
      tick();
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    // Fairness: all four valid, requester 0 needs two ops
    rem = '{2, 1, 1, 1};
    run_accepts(5, cyc);
    chk("fair_cycles", cyc, 5);
    for (int k = 0; k < 5 && k < acc_q.size(); k++) chk("fair_order", acc_q[k], k % N);
    // Single op with one-cycle latency
    issue(0, 8'd200, 8'd100, ALU_ADD, 8'd44, 1'b1, 1'b0);
    tick();
    chk("single_valid", resp_valid, 1);
    chk("single_result", resp_result, 44);
    chk("single_carry", resp_carry, 1);
    chk("single_err", resp_err, 0);
    chk("single_id", resp_id, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++)
      issue(k % N, tbl[k].a, tbl[k].b, tbl[k].op, tbl[k].res, tbl[k].c, tbl[k].e);
    repeat (3) step();
    chk("table_drain", expq.size(), 0);
    // Backpressure: response held, nothing accepted, then accept on the release cycle
    issue(2, 8'd7, 8'd3, ALU_SUB, 8'd4, 1'b0, 1'b0);
    resp_ready = 1'b0;
    set_req(3, 8'd5, 8'd6, ALU_ADD, 8'd11, 1'b0, 1'b0);
    req_valid[3] = 1'b1;
    repeat (3) begin
      tick();
      chk("bp_valid", resp_valid, 1);
      chk("bp_result", resp_result, 4);
      chk("bp_id", resp_id, 2);
      chk("bp_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_release_ready", req_ready, 4'b1000);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    // Lock with LOCK_MAX=2: pointer to 1 first, then 1 locked and 2 waiting
    issue(0, 8'd1, 8'd2, ALU_ADD, 8'd3, 1'b0, 1'b0);
    set_req(1, 8'd50, 8'd5, ALU_SUB, 8'd45, 1'b0, 1'b0);
    set_req(2, 8'd3, 8'd4, ALU_MUL, 8'd12, 1'b0, 1'b0);
    req_lock = 4'b0010;
    rem = '{0, 99, 1, 0};
    req_valid = 4'b0110;
    run_accepts(4, cyc);
    for (int k = 0; k < 4 && k < acc_q.size(); k++) chk("lock_order", acc_q[k], (k == 2) ? 2 : 1);
    resp_ready = 1'b0;
    set_req(0, 8'd1, 8'd1, ALU_ADD, 8'd2, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    tick();
    chk("locked_hold_ready", req_ready, 0);
    chk("locked_resp_id", resp_id, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_result", resp_result, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    tick();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    tick();
    chk("post_rst_arb_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rem = '{0, 1, 0, 0};
    run_accepts(1, cyc);
    chk("post_rst_next", acc_q.size() > 0 ? acc_q[0] : -1, 1);
    req_lock = '0;
    repeat (3) step();
    chk("final_drain", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
